// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and clear pulse in, byte/flags out.
// dbg_recv is 1 while the receiver is inside a frame.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       dbg_recv;

    // rdy is a level: it stays high until clr_rdy is pulsed for one cycle or
    // the next frame starts; there is no back-pressure on the serial side.
    modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err, dbg_recv);
    modport master (output RX, clr_rdy, input rx_data, rdy, frm_err, dbg_recv);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, byte + ready flag.
// Sample k of a frame lands on edge T + HALF + k*BAUD_DIV after start detect T.
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);
    localparam int HALF = BAUD_DIV / 2;
    localparam int BW   = $clog2(BAUD_DIV);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          rdy_q, rdy_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= bus.RX;
            sync2_q <= sync1_q;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    // The counter runs down to zero, so it is loaded with one less than the
    // interval; that keeps BAUD_DIV-1 representable in $clog2(BAUD_DIV) bits.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        ferr_d  = ferr_q;

        if (bus.clr_rdy) begin
            rdy_d  = 1'b0;
            ferr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = RECV;
                    baud_d  = BW'(HALF - 1);
                    bit_d   = '0;
                    rdy_d   = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            RECV: begin
                if (baud_q == '0) begin
                    baud_d = BW'(BAUD_DIV - 1);
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd0) begin
                        if (sync2_q) state_d = IDLE;
                    end else if (bit_q == 4'd9) begin
                        data_d  = shift_q;
                        rdy_d   = 1'b1;
                        ferr_d  = ~sync2_q;
                        state_d = IDLE;
                    end else begin
                        shift_d = {sync2_q, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_data  = data_q;
    assign bus.rdy      = rdy_q;
    assign bus.frm_err  = ferr_q;
    assign bus.dbg_recv = (state_q == RECV);
endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: a fast instance (BAUD_DIV=16) and a
// default-rate instance (BAUD_DIV=2604) driven by a bit-level serial model.
module tb_uart_rx;
    localparam int DIV_F = 16;
    localparam int DIV_S = 2604;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic rx_f = 1'b1, clr_f = 1'b0, rx_s = 1'b1, clr_s = 1'b0;
    logic [8:0] exp_q[$];

    uart_rx_if if_f ();
    uart_rx_if if_s ();
    assign if_f.RX = rx_f;
    assign if_f.clr_rdy = clr_f;
    assign if_s.RX = rx_s;
    assign if_s.clr_rdy = clr_s;

    uart_rx #(.BAUD_DIV(DIV_F)) u_fast (.clk(clk), .rst_n(rst_n), .bus(if_f));
    uart_rx #(.BAUD_DIV(DIV_S)) u_slow (.clk(clk), .rst_n(rst_n), .bus(if_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_rdy(input bit slow);
        return slow ? if_s.rdy : if_f.rdy;
    endfunction
    function automatic logic get_ferr(input bit slow);
        return slow ? if_s.frm_err : if_f.frm_err;
    endfunction
    function automatic logic [7:0] get_data(input bit slow);
        return slow ? if_s.rx_data : if_f.rx_data;
    endfunction

    task automatic set_line(input bit slow, input logic rx, input logic clr);
        if (slow) begin rx_s = rx; clr_s = clr; end
        else begin rx_f = rx; clr_f = clr; end
    endtask

    task automatic idle(input int n);
        rx_f = 1'b1; clr_f = 1'b0; rx_s = 1'b1; clr_s = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reference result of a frame: frm_err in bit 8, byte below.
    function automatic logic [8:0] model(input logic [7:0] b, input bit stop);
        return {~stop, b};
    endfunction

    // Drives one frame; T is the third edge after the line falls (two sync
    // flops then the detecting edge). A zero stop bit is released right after
    // its sample point so it is not taken for the next start bit.
    task automatic send_frame(input bit slow, input logic [7:0] b, input bit stop,
                              input int clr_at, input int rst_at,
                              output int t_edge, output int rise,
                              output logic [7:0] d_rise, output logic f_rise,
                              output logic rdy_pre_t, output logic rdy_at_t);
        int div;
        int n0;
        logic [9:0] bits;
        logic v;
        div = slow ? DIV_S : DIV_F;
        bits = {stop, b, 1'b0};
        n0 = cyc;
        t_edge = n0 + 3;
        rise = -1;
        d_rise = 'x;
        f_rise = 'x;
        rdy_pre_t = 'x;
        rdy_at_t = 'x;
        for (int i = 0; i < 10 * div; i++) begin
            v = bits[i / div];
            if (i / div == 9 && !stop && (i % div) >= div / 2 + 1) v = 1'b1;
            set_line(slow, v, clr_at >= 0 && cyc == t_edge + clr_at - 1);
            rst_n = !(rst_at >= 0 && i == rst_at);
            @(negedge clk);
            if (cyc == t_edge - 1) rdy_pre_t = get_rdy(slow);
            if (cyc == t_edge) rdy_at_t = get_rdy(slow);
            if (rst_at >= 0 && i == rst_at) begin
                chk("rst_mid_data", get_data(slow), 8'h00);
                chk("rst_mid_rdy", get_rdy(slow), 1'b0);
                chk("rst_mid_ferr", get_ferr(slow), 1'b0);
                chk("rst_mid_state", slow ? if_s.dbg_recv : if_f.dbg_recv, 1'b0);
            end
            if (cyc >= t_edge && rise < 0 && get_rdy(slow)) begin
                rise = cyc;
                d_rise = get_data(slow);
                f_rise = get_ferr(slow);
            end
        end
        set_line(slow, 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    // Sends a frame and checks it against the reference model.
    task automatic run_check(input string tag, input bit slow, input logic [7:0] b,
                             input bit stop, input int clr_at);
        int t, r, div, off;
        logic [7:0] d;
        logic f, rp, rt, end_rdy;
        logic [8:0] e;
        div = slow ? DIV_S : DIV_F;
        off = div / 2 + 9 * div;
        exp_q.push_back(model(b, stop));
        send_frame(slow, b, stop, clr_at, -1, t, r, d, f, rp, rt);
        e = exp_q.pop_front();
        chk({tag, "_rise_cyc"}, r, t + off);
        chk({tag, "_data"}, d, e[7:0]);
        chk({tag, "_ferr"}, f, e[8]);
        chk({tag, "_rdy_at_t"}, rt, 1'b0);
        end_rdy = !(clr_at > off);
        chk({tag, "_end_rdy"}, get_rdy(slow), end_rdy);
        chk({tag, "_end_ferr"}, get_ferr(slow), end_rdy & e[8]);
    endtask

    task automatic pulse_clr(input bit slow, input logic [7:0] held);
        set_line(slow, 1'b1, 1'b1);
        @(negedge clk);
        set_line(slow, 1'b1, 1'b0);
        chk("clr_rdy", get_rdy(slow), 1'b0);
        chk("clr_ferr", get_ferr(slow), 1'b0);
        chk("clr_data_held", get_data(slow), held);
    endtask

    initial begin
        int t, r, n0, clr_at, gap;
        logic [7:0] d, b;
        logic f, rp, rt, stop;

        // Reset, then an idle line for 12 bit times
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        chk("reset_data_f", if_f.rx_data, 8'h00);
        chk("reset_rdy_f", if_f.rdy, 1'b0);
        chk("reset_ferr_f", if_f.frm_err, 1'b0);
        chk("reset_state_f", if_f.dbg_recv, 1'b0);
        chk("reset_rdy_s", if_s.rdy, 1'b0);
        for (int k = 0; k < 12; k++) begin
            idle(DIV_F);
            chk("idle_rdy", if_f.rdy, 1'b0);
            chk("idle_data", if_f.rx_data, 8'h00);
            chk("idle_ferr", if_f.frm_err, 1'b0);
        end
        chk("idle_rdy_s", if_s.rdy, 1'b0);
        chk("idle_data_s", if_s.rx_data, 8'h00);

        // Default baud rate: exact rise latency and clear handshake
        send_frame(1'b1, 8'h00, 1'b1, -1, -1, t, r, d, f, rp, rt);
        chk("slow00_latency", r - t, 24738);
        chk("slow00_data", d, 8'h00);
        chk("slow00_ferr", f, 1'b0);
        pulse_clr(1'b1, 8'h00);
        idle(5);
        send_frame(1'b1, 8'h76, 1'b1, -1, -1, t, r, d, f, rp, rt);
        chk("slow76_latency", r - t, 24738);
        chk("slow76_data", d, 8'h76);
        chk("slow76_ferr", f, 1'b0);
        pulse_clr(1'b1, 8'h76);

        // False start: line low for 5 clocks only
        idle(4);
        n0 = cyc;
        rx_f = 1'b0;
        repeat (5) @(negedge clk);
        rx_f = 1'b1;
        while (cyc < n0 + 10) @(negedge clk);
        chk("false_in_recv", if_f.dbg_recv, 1'b1);
        @(negedge clk);
        chk("false_back_idle", if_f.dbg_recv, 1'b0);
        idle(2 * DIV_F);
        chk("false_rdy", if_f.rdy, 1'b0);
        chk("false_data", if_f.rx_data, 8'h00);
        run_check("a5", 1'b0, 8'hA5, 1'b1, -1);

        // Framing error still delivers the byte
        idle(7);
        run_check("ferr3c", 1'b0, 8'h3C, 1'b0, -1);
        pulse_clr(1'b0, 8'h3C);

        // Back-to-back; second frame also gets clr_rdy on its stop-sample edge
        idle(3);
        run_check("b2b55", 1'b0, 8'h55, 1'b1, -1);
        exp_q.push_back(model(8'hAA, 1'b1));
        send_frame(1'b0, 8'hAA, 1'b1, DIV_F / 2 + 9 * DIV_F, -1, t, r, d, f, rp, rt);
        void'(exp_q.pop_front());
        chk("b2b_rdy_before_t", rp, 1'b1);
        chk("b2b_rdy_at_t", rt, 1'b0);
        chk("b2bAA_rise_cyc", r, t + DIV_F / 2 + 9 * DIV_F);
        chk("b2bAA_data", d, 8'hAA);
        chk("b2bAA_set_wins", if_f.rdy, 1'b1);

        // Reset for one clock during data bit 4 of 8'hF0
        idle(6);
        send_frame(1'b0, 8'hF0, 1'b1, -1, 5 * DIV_F + 8, t, r, d, f, rp, rt);
        chk("rstF0_no_rise", r, -1);
        idle(2 * DIV_F);
        chk("rstF0_rdy", if_f.rdy, 1'b0);
        chk("rstF0_data", if_f.rx_data, 8'h00);
        run_check("after_rst0f", 1'b0, 8'h0F, 1'b1, -1);

        // Randomized frames: byte, stop bit, idle gap and clear point
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            clr_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 10 * DIV_F - 3)) : -1;
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            if (gap > 0) idle(gap);
            run_check("rand", 1'b0, b, stop, clr_at);
        end

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that consumes the serial stream produced by the design's UART transmitter. It recovers 8N1 frames (one start bit, eight data bits LSB-first, one stop bit) from an asynchronous RX line and presents each byte with a ready flag. A downstream command/response block consumes that flag through a `clr_rdy` handshake. The block pairs with the transmitter in loopback benches and carries the same baud-divider convention, so both ends agree on bit timing.

## Interface
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); legal range ≥ 4, even values only.
- clk  input  1  system clock; every flop is clocked on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- RX  input  1  asynchronous serial input; idles high.
- clr_rdy  input  1  single-cycle pulse from the consumer; acknowledges and clears `rdy`.
- rx_data  output  8  last received byte; holds until the next frame completes.
- rdy  output  1  high when a completed frame is waiting in `rx_data`.
- frm_err  output  1  the last completed frame had stop bit = 0.

## Operation
- Synchronizer: RX passes through two flops, sync1 and sync2, both reset to 1. All logic uses sync2 only.
- Parameters:
  - HALF = BAUD_DIV/2.
  - Baud counter width is $clog2(BAUD_DIV).
  - Bit counter width is 4 bits.
- States:
  - IDLE: wait for a start bit.
  - RECV: sample 10 bits.
- IDLE → RECV when sync2 == 0 (the start-detect edge, T). At that edge:
  - baud counter loads HALF;
  - bit counter clears;
  - rdy and frm_err clear.
- In RECV, sample k (k = 0..9) is taken on the edge T + HALF + k·BAUD_DIV. The baud counter reloads BAUD_DIV after each sample.
- k = 0 (start bit):
  - sync2 == 1 is a false start. Return to IDLE without changing rx_data. rdy and frm_err stay 0, because they were already cleared at T.
  - sync2 == 0 continues the frame.
- k = 1..8: sync2 shifts into the shift register from the MSB side, so the first data bit ends up in bit 0.
- k = 9 (stop bit), on the same edge:
  - rx_data ← shift register;
  - rdy ← 1;
  - frm_err ← ~sync2;
  - return to IDLE.
- A byte with a framing error is still delivered: rdy = 1 and frm_err = 1.
- clr_rdy in any state clears rdy and frm_err on the next edge.
- clr_rdy on the same edge as the stop sample: the set wins (rdy = 1).
- RX activity in RECV never restarts the frame. Only the sample points matter.
- After the stop sample, IDLE re-arms immediately. A following start bit is detected as soon as sync2 == 0.

## Timing
- Reset values:
  - rx_data = 8'h00, rdy = 0, frm_err = 0;
  - state = IDLE, sync1 = sync2 = 1;
  - counters = 0.
- Reset is synchronous. Asserting it mid-frame aborts the frame at the next edge. No partial byte reaches rx_data.
- Latency from the RX falling edge to T is 2–3 clocks (synchronizer).
- rdy rises on edge T + HALF + 9·BAUD_DIV. With the default BAUD_DIV this is T + 24738.
- rdy falls on the edge after clr_rdy is sampled, or at the next T, whichever comes first.
- No rdy-based back-pressure exists. A new frame overwrites rx_data whether or not clr_rdy was seen.
- Throughput: back-to-back frames at exactly 10·BAUD_DIV spacing must all be received.

## Test plan
- Reset: hold rst_n = 0 for 3 clocks, then RX = 1 for 12 bit times → rdy = 0, frm_err = 0, rx_data = 8'h00 throughout.
- Loopback with the UART transmitter, BAUD_DIV = 2604: send 8'h00, then 8'h76 →
  - rx_data = 8'h00 and then 8'h76, each with rdy = 1 and frm_err = 0;
  - rdy rises 24738 clocks after T (±0);
  - a clr_rdy pulse drops rdy on the next edge.
- False start, BAUD_DIV = 16: RX low for 5 clocks, then high →
  - no rdy, state returns to IDLE after sample 0;
  - the following frame 8'hA5 gives rx_data = 8'hA5, rdy = 1.
- Framing error, BAUD_DIV = 16: frame 8'h3C with stop bit driven 0 → rx_data = 8'h3C, rdy = 1, frm_err = 1. A clr_rdy pulse clears both.
- Back-to-back, BAUD_DIV = 16: 8'h55 immediately followed by 8'hAA, no clr_rdy →
  - rdy = 1 with 8'h55;
  - rdy drops at the second T;
  - rdy = 1 with 8'hAA. Also pulse clr_rdy on the stop-sample edge → rdy stays 1.
- Reset mid-frame, BAUD_DIV = 16: rst_n = 0 for one clock during data bit 4 of 8'hF0 →
  - outputs return to reset values on the next edge;
  - no rdy for the aborted frame;
  - the next full frame 8'h0F gives rx_data = 8'h0F.
